// File: rtl/rect_pixel_source.sv
// Pixel source for the 240x135 LCD: colours a linear pixel index from a committed
// list of prioritised filled rectangles, tracking (x,y) incrementally without a divider.
module rect_pixel_source #(
    parameter int unsigned H_RES    = 240,
    parameter int unsigned V_RES    = 135,
    parameter int unsigned NRECT    = 4,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] pixel_index,
    output logic [15:0] pixel_value,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_slot,
    input  logic [2:0]  wr_field,
    input  logic [15:0] wr_data,
    input  logic        commit,
    output logic        commit_pending,
    output logic        seq_err
);

    localparam int unsigned NPIX   = H_RES * V_RES;
    localparam logic [15:0] NPIX16 = 16'(NPIX);
    localparam logic [7:0]  XLAST  = 8'(H_RES - 1);

    typedef enum logic {
        TRACK = 1'b0,
        LOST  = 1'b1
    } state_e;

    logic [7:0]  sh_x0_q    [NRECT];
    logic [7:0]  sh_x1_q    [NRECT];
    logic [7:0]  sh_y0_q    [NRECT];
    logic [7:0]  sh_y1_q    [NRECT];
    logic [15:0] sh_color_q [NRECT];
    logic        sh_en_q    [NRECT];

    logic [7:0]  act_x0_q    [NRECT];
    logic [7:0]  act_x1_q    [NRECT];
    logic [7:0]  act_y0_q    [NRECT];
    logic [7:0]  act_y1_q    [NRECT];
    logic [15:0] act_color_q [NRECT];
    logic        act_en_q    [NRECT];

    state_e      state_q, state_d;
    logic [15:0] cur_idx_q, cur_idx_d;
    logic [7:0]  cur_x_q, cur_x_d;
    logic [7:0]  cur_y_q, cur_y_d;
    logic        seq_err_q, seq_err_d;
    logic        pending_q, pending_d;

    logic        oor_c;
    logic        idle_c;
    logic        look_c;
    logic        wr_fire_c;
    logic        commit_fire_c;
    logic [15:0] color_c;

    assign oor_c         = (pixel_index >= NPIX16);
    assign idle_c        = (pixel_index == 16'd0) || oor_c;
    assign wr_fire_c     = wr_valid && !pending_q;
    assign commit_fire_c = pending_q && idle_c;

    assign wr_ready       = ~pending_q;
    assign commit_pending = pending_q;
    assign seq_err        = seq_err_q;
    assign pixel_value    = color_c;

    // Index classification: decides the (x,y) of this cycle and the tracker update.
    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        seq_err_d = seq_err_q;
        look_c    = 1'b0;
        if (state_q == TRACK) begin
            if (oor_c) begin
                look_c = 1'b0;
            end else if (pixel_index == 16'd0) begin
                cur_idx_d = 16'd0;
                cur_x_d   = 8'd0;
                cur_y_d   = 8'd0;
                look_c    = 1'b1;
            end else if (pixel_index == cur_idx_q) begin
                look_c = 1'b1;
            end else if (pixel_index == 16'(cur_idx_q + 16'd1)) begin
                cur_idx_d = pixel_index;
                look_c    = 1'b1;
                if (cur_x_q == XLAST) begin
                    cur_x_d = 8'd0;
                    cur_y_d = 8'(cur_y_q + 8'd1);
                end else begin
                    cur_x_d = 8'(cur_x_q + 8'd1);
                end
            end else begin
                state_d   = LOST;
                seq_err_d = 1'b1;
            end
        end else if (pixel_index == 16'd0) begin
            state_d   = TRACK;
            cur_idx_d = 16'd0;
            cur_x_d   = 8'd0;
            cur_y_d   = 8'd0;
            look_c    = 1'b1;
        end
    end

    // Priority lookup: scanning downwards lets the lowest covering slot win.
    always_comb begin
        color_c = BG_COLOR;
        if (look_c) begin
            for (int i = int'(NRECT) - 1; i >= 0; i--) begin
                if (act_en_q[i] &&
                    cur_x_d >= act_x0_q[i] && cur_x_d <= act_x1_q[i] &&
                    cur_y_d >= act_y0_q[i] && cur_y_d <= act_y1_q[i]) begin
                    color_c = act_color_q[i];
                end
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (commit_fire_c) begin
            pending_d = 1'b0;
        end else if (commit && !pending_q) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= TRACK;
            cur_idx_q <= 16'd0;
            cur_x_q   <= 8'd0;
            cur_y_q   <= 8'd0;
            seq_err_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            seq_err_q <= seq_err_d;
            pending_q <= pending_d;
        end
    end

    // Shadow writes and commit copy never coincide: writes are blocked while pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NRECT); i++) begin
                sh_x0_q[i]     <= 8'd0;
                sh_x1_q[i]     <= 8'd0;
                sh_y0_q[i]     <= 8'd0;
                sh_y1_q[i]     <= 8'd0;
                sh_color_q[i]  <= 16'd0;
                sh_en_q[i]     <= 1'b0;
                act_x0_q[i]    <= 8'd0;
                act_x1_q[i]    <= 8'd0;
                act_y0_q[i]    <= 8'd0;
                act_y1_q[i]    <= 8'd0;
                act_color_q[i] <= 16'd0;
                act_en_q[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(NRECT); i++) begin
                if (wr_fire_c && wr_slot == 3'(i)) begin
                    case (wr_field)
                        3'd0:    sh_x0_q[i]    <= wr_data[7:0];
                        3'd1:    sh_x1_q[i]    <= wr_data[7:0];
                        3'd2:    sh_y0_q[i]    <= wr_data[7:0];
                        3'd3:    sh_y1_q[i]    <= wr_data[7:0];
                        3'd4:    sh_color_q[i] <= wr_data;
                        3'd5:    sh_en_q[i]    <= wr_data[0];
                        default: ;
                    endcase
                end
                if (commit_fire_c) begin
                    act_x0_q[i]    <= sh_x0_q[i];
                    act_x1_q[i]    <= sh_x1_q[i];
                    act_y0_q[i]    <= sh_y0_q[i];
                    act_y1_q[i]    <= sh_y1_q[i];
                    act_color_q[i] <= sh_color_q[i];
                    act_en_q[i]    <= sh_en_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rect_pixel_source.sv
// Directed bench for rect_pixel_source: walks the pixel index like the LCD controller
// and spot-checks colours, commit handshake and sequence-error behaviour.
module tb_rect_pixel_source;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] pixel_index;
    logic [15:0] pixel_value;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_slot;
    logic [2:0]  wr_field;
    logic [15:0] wr_data;
    logic        commit;
    logic        commit_pending;
    logic        seq_err;

    int checks   = 0;
    int failures = 0;
    int tb_idx   = 0;

    rect_pixel_source dut (
        .clk            (clk),
        .resetn         (resetn),
        .pixel_index    (pixel_index),
        .pixel_value    (pixel_value),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_slot        (wr_slot),
        .wr_field       (wr_field),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .seq_err        (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance the index by one per clock up to t, leaving t applied but not yet clocked.
    task automatic goto(input int t);
        while (tb_idx < t) begin
            cyc();
            tb_idx++;
            pixel_index = 16'(tb_idx);
        end
        #1;
    endtask

    task automatic restart();
        cyc();
        tb_idx      = 0;
        pixel_index = 16'd0;
        #1;
    endtask

    task automatic wr(input logic [2:0] slot, input logic [2:0] field, input logic [15:0] data);
        wr_slot  = slot;
        wr_field = field;
        wr_data  = data;
        wr_valid = 1'b1;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic wr_rect(input logic [2:0] slot, input logic [7:0] x0, input logic [7:0] x1,
                           input logic [7:0] y0, input logic [7:0] y1,
                           input logic [15:0] color, input logic en);
        wr(slot, 3'd0, {8'd0, x0});
        wr(slot, 3'd1, {8'd0, x1});
        wr(slot, 3'd2, {8'd0, y0});
        wr(slot, 3'd3, {8'd0, y1});
        wr(slot, 3'd4, color);
        wr(slot, 3'd5, {15'd0, en});
    endtask

    initial begin
        resetn      = 1'b0;
        pixel_index = 16'd0;
        wr_valid    = 1'b0;
        wr_slot     = 3'd0;
        wr_field    = 3'd0;
        wr_data     = 16'd0;
        commit      = 1'b0;
        #12;
        chk("rst_pixel",   pixel_value, 16'h0000);
        chk("rst_ready",   16'(wr_ready), 16'd1);
        chk("rst_pending", 16'(commit_pending), 16'd0);
        chk("rst_seqerr",  16'(seq_err), 16'd0);
        resetn = 1'b1;
        cyc();

        // Empty list: everything is background.
        goto(250);
        chk("empty_250", pixel_value, 16'h0000);
        chk("empty_seqerr", 16'(seq_err), 16'd0);

        // Slot0 red rectangle, invisible until committed.
        restart();
        wr_rect(3'd0, 8'd10, 8'd20, 8'd5, 8'd6, 16'hF800, 1'b1);
        goto(1210);
        chk("precommit_1210", pixel_value, 16'h0000);
        restart();
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        chk("commit_pend_set", 16'(commit_pending), 16'd1);
        chk("commit_ready_lo", 16'(wr_ready), 16'd0);
        cyc();
        chk("commit_pend_clr", 16'(commit_pending), 16'd0);
        goto(1209);
        chk("r0_1209", pixel_value, 16'h0000);
        goto(1210);
        chk("r0_1210", pixel_value, 16'hF800);
        repeat (8) cyc();
        chk("r0_hold_1210", pixel_value, 16'hF800);
        goto(1220);
        chk("r0_1220", pixel_value, 16'hF800);
        goto(1221);
        chk("r0_1221", pixel_value, 16'h0000);
        goto(1450);
        chk("r0_1450", pixel_value, 16'hF800);
        goto(1690);
        chk("r0_1690", pixel_value, 16'h0000);

        // Overlapping full-width rows: slot0 wins on row 0.
        restart();
        wr_rect(3'd0, 8'd0, 8'd239, 8'd0, 8'd0, 16'h001F, 1'b1);
        wr_rect(3'd1, 8'd0, 8'd239, 8'd0, 8'd134, 16'h07E0, 1'b1);
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        cyc();
        chk("ov_0", pixel_value, 16'h001F);
        goto(239);
        chk("ov_239", pixel_value, 16'h001F);
        goto(240);
        chk("ov_240", pixel_value, 16'h07E0);
        goto(500);
        chk("ov_500", pixel_value, 16'h07E0);

        // Mid-frame commit with a same-cycle write; waits for index NPIX.
        wr_slot  = 3'd1;
        wr_field = 3'd4;
        wr_data  = 16'h1234;
        wr_valid = 1'b1;
        commit   = 1'b1;
        cyc();
        wr_valid = 1'b0;
        commit   = 1'b0;
        chk("mid_pend", 16'(commit_pending), 16'd1);
        chk("mid_ready", 16'(wr_ready), 16'd0);
        goto(501);
        chk("mid_501_old", pixel_value, 16'h07E0);
        goto(600);
        wr(3'd0, 3'd4, 16'hBEEF);
        goto(32399);
        chk("mid_last_old", pixel_value, 16'h07E0);
        chk("mid_last_pend", 16'(commit_pending), 16'd1);
        goto(32400);
        chk("oor_bg", pixel_value, 16'h0000);
        cyc();
        chk("oor_pend_clr", 16'(commit_pending), 16'd0);
        chk("oor_ready", 16'(wr_ready), 16'd1);
        restart();
        chk("new_0_no_blocked_wr", pixel_value, 16'h001F);
        goto(240);
        chk("new_240", pixel_value, 16'h1234);

        // Out-of-sequence index: 0,1,2,7.
        restart();
        cyc(); pixel_index = 16'd1;
        cyc(); pixel_index = 16'd2;
        cyc(); pixel_index = 16'd7;
        #1;
        chk("jump_pre_seqerr", 16'(seq_err), 16'd0);
        chk("jump_bg", pixel_value, 16'h0000);
        cyc();
        chk("jump_seqerr", 16'(seq_err), 16'd1);
        chk("lost_7", pixel_value, 16'h0000);
        pixel_index = 16'd8;
        #1;
        chk("lost_8", pixel_value, 16'h0000);
        cyc();
        pixel_index = 16'd0;
        tb_idx      = 0;
        #1;
        chk("resync_0", pixel_value, 16'h001F);
        goto(240);
        chk("resync_240", pixel_value, 16'h1234);
        chk("seqerr_sticky", 16'(seq_err), 16'd1);

        // Inverted rectangle and out-of-range slot contribute nothing.
        restart();
        wr(3'd0, 3'd5, 16'd0);
        wr(3'd1, 3'd5, 16'd0);
        wr_rect(3'd2, 8'd30, 8'd20, 8'd0, 8'd134, 16'hF0F0, 1'b1);
        wr_rect(3'd5, 8'd0, 8'd239, 8'd0, 8'd134, 16'hABCD, 1'b1);
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        cyc();
        chk("inv_0", pixel_value, 16'h0000);
        goto(25);
        chk("inv_25", pixel_value, 16'h0000);
        goto(300);
        chk("inv_300", pixel_value, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
